csi_tx_clock_lane: RTL

CSI_TX_CLOCK_LANE -- requirements
Module: csi_tx_clock_lane

---
 rtl/csi_tx_pkg.sv | 34 +++
 rtl/csi_tx_clock_lane_if.sv | 14 +
 rtl/csi_tx_clock_lane.sv | 116 +++++++++++
 3 files changed

// File: rtl/csi_tx_pkg.sv
// Shared types for the CSI-2 TX clock lane: lane state encoding and LP line levels.
package csi_tx_pkg;

    typedef enum logic [3:0] {
        ST_STOP,
        ST_LPX,
        ST_PREP,
        ST_ZERO,
        ST_PRE,
        ST_RUN,
        ST_POST,
        ST_TRAIL,
        ST_EXIT
    } lane_state_e;

    // LP line state as {Dp,Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // Successor of a timed state once its duration has elapsed.
    function automatic lane_state_e timed_next(input lane_state_e s);
        case (s)
            ST_LPX:   return ST_PREP;
            ST_PREP:  return ST_ZERO;
            ST_ZERO:  return ST_PRE;
            ST_PRE:   return ST_RUN;
            ST_POST:  return ST_TRAIL;
            ST_TRAIL: return ST_EXIT;
            default:  return ST_STOP;
        endcase
    endfunction

endpackage

// File: rtl/csi_tx_clock_lane_if.sv
// Control/status bundle between a lane controller and the clock lane PHY sequencer.
interface csi_tx_clock_lane_if;
    import csi_tx_pkg::*;

    logic       clk_req;
    logic [1:0] lp_out;
    logic       hs_oe;
    logic       hs_gate;
    logic       clk_ready;
    logic       lane_busy;

    modport master (output clk_req, input lp_out, hs_oe, hs_gate, clk_ready, lane_busy);
    modport slave  (input clk_req, output lp_out, hs_oe, hs_gate, clk_ready, lane_busy);
endinterface

// File: rtl/csi_tx_clock_lane.sv
// CSI-2 TX clock lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> toggling clock, and the
// reverse HS trail/exit when the request drops. All outputs are registered.
module csi_tx_clock_lane
    import csi_tx_pkg::*;
#(
    parameter int T_LPX     = 2,
    parameter int T_PREPARE = 2,
    parameter int T_ZERO    = 8,
    parameter int T_PRE     = 2,
    parameter int T_POST    = 8,
    parameter int T_TRAIL   = 2,
    parameter int T_HS_EXIT = 3
) (
    input  logic       ref_clock,
    input  logic       reset_in,
    input  logic       clk_req,
    output logic [1:0] lp_out,
    output logic       hs_oe,
    output logic       hs_gate,
    output logic       clk_ready,
    output logic       lane_busy
);

    if (T_LPX < 1 || T_LPX > 255 || T_PREPARE < 1 || T_PREPARE > 255 ||
        T_ZERO < 1 || T_ZERO > 255 || T_PRE < 1 || T_PRE > 255 ||
        T_POST < 1 || T_POST > 255 || T_TRAIL < 1 || T_TRAIL > 255 ||
        T_HS_EXIT < 1 || T_HS_EXIT > 255) begin : g_bad_timing
        $error("csi_tx_clock_lane: every T_* parameter must be in 1..255");
    end

    // Counter preload on entry; STOP and RUN are untimed and park at 0.
    function automatic logic [7:0] load_of(input lane_state_e s);
        case (s)
            ST_LPX:   return 8'(T_LPX - 1);
            ST_PREP:  return 8'(T_PREPARE - 1);
            ST_ZERO:  return 8'(T_ZERO - 1);
            ST_PRE:   return 8'(T_PRE - 1);
            ST_POST:  return 8'(T_POST - 1);
            ST_TRAIL: return 8'(T_TRAIL - 1);
            ST_EXIT:  return 8'(T_HS_EXIT - 1);
            default:  return 8'd0;
        endcase
    endfunction

    lane_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lp_q, lp_d;
    logic        hs_oe_q, hs_oe_d;
    logic        hs_gate_q, hs_gate_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STOP: if (clk_req)  state_d = ST_LPX;
            ST_RUN:  if (!clk_req) state_d = ST_POST;
            default: begin
                // Start-up and shutdown run to completion regardless of clk_req.
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else               state_d = timed_next(state_q);
            end
        endcase
        if (state_d != state_q) cnt_d = load_of(state_d);

        // Outputs decoded from the next state so they change on the transition edge.
        lp_d      = LP00;
        hs_oe_d   = 1'b0;
        hs_gate_d = 1'b0;
        ready_d   = 1'b0;
        busy_d    = (state_d != ST_STOP);
        case (state_d)
            ST_STOP, ST_EXIT: lp_d = LP11;
            ST_LPX:           lp_d = LP01;
            ST_ZERO, ST_TRAIL: hs_oe_d = 1'b1;
            ST_PRE, ST_POST: begin
                hs_oe_d   = 1'b1;
                hs_gate_d = 1'b1;
            end
            ST_RUN: begin
                hs_oe_d   = 1'b1;
                hs_gate_d = 1'b1;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ref_clock) begin
        if (reset_in) begin
            state_q   <= ST_STOP;
            cnt_q     <= 8'd0;
            lp_q      <= LP11;
            hs_oe_q   <= 1'b0;
            hs_gate_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lp_q      <= lp_d;
            hs_oe_q   <= hs_oe_d;
            hs_gate_q <= hs_gate_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign lp_out    = lp_q;
    assign hs_oe     = hs_oe_q;
    assign hs_gate   = hs_gate_q;
    assign clk_ready = ready_q;
    assign lane_busy = busy_q;

endmodule
